// File: rtl/regfile_arbiter_pkg.sv
// Shared sizes and FSM state encoding for the register-file port arbiter.
package regfile_arb_pkg;

    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 8;

    typedef enum logic [1:0] {
        IDLE,
        DBG_ACC,
        DBG_ACK,
        CLEAR
    } arb_state_t;

endpackage

// File: rtl/regfile_arbiter_if.sv
// Debug-host access channel into the register-file arbiter.
interface regfile_arbiter_if;
    import regfile_arb_pkg::*;

    // Handshake: the host raises dbg_req with dbg_wr/dbg_addr/dbg_wdata stable and holds it
    // until dbg_ack (a one-cycle pulse); dbg_rdata is valid with dbg_ack and held afterwards.
    logic              dbg_req;
    logic              dbg_wr;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;

    modport master (
        output dbg_req, dbg_wr, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata
    );

    modport slave (
        input  dbg_req, dbg_wr, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata
    );

endinterface

// File: rtl/regfile_starve_cnt.sv
// Saturating count of cycles a pending debug request has lost the write port to the core.
module regfile_starve_cnt #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_V)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_max = (cnt == MAX_V);

endmodule

// File: rtl/regfile_arbiter.sv
// Shares the register file's write port and src1 read port between the core, a debug host
// and a hardware clear sequencer. The core wins unless a debug request has starved too long.
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int                MAX_WAIT  = 4,
    parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                core_we,
    input  logic [ADDR_W-1:0]   core_dst,
    input  logic [DATA_W-1:0]   core_data,
    input  logic [ADDR_W-1:0]   core_src1,
    output logic                core_stall,
    regfile_arbiter_if.slave    dbg,
    input  logic                clr_start,
    output logic                clr_done,
    output logic                rf_we,
    output logic [ADDR_W-1:0]   rf_dst,
    output logic [DATA_W-1:0]   rf_data,
    output logic [ADDR_W-1:0]   rf_src1,
    input  logic [DATA_W-1:0]   rf_data1,
    output arb_state_t          fsm_state
);

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(NUM_REGS - 1);

    arb_state_t        state;
    logic              clr_pend;
    logic [ADDR_W-1:0] clr_cnt;
    logic              at_max;
    logic              clr_go;
    logic              dbg_grant;
    logic              wait_inc;
    logic              wait_clr;

    assign clr_go    = clr_pend | clr_start;
    // A pending clear always beats a debug grant in the same decision cycle.
    assign dbg_grant = !clr_go && dbg.dbg_req && (!core_we || at_max);
    assign wait_inc  = (state == IDLE) && dbg.dbg_req && core_we;
    assign wait_clr  = (state == IDLE) && dbg_grant;

    regfile_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (wait_inc),
        .clr    (wait_clr),
        .at_max (at_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            clr_pend      <= 1'b0;
            clr_cnt       <= '0;
            clr_done      <= 1'b0;
            dbg.dbg_ack   <= 1'b0;
            dbg.dbg_rdata <= '0;
        end else begin
            dbg.dbg_ack <= 1'b0;
            clr_done    <= 1'b0;
            if (clr_start) begin
                clr_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (clr_go) begin
                        state    <= CLEAR;
                        clr_pend <= 1'b0;
                        clr_cnt  <= '0;
                    end else if (dbg_grant) begin
                        state <= DBG_ACC;
                    end
                end
                DBG_ACC: begin
                    if (!dbg.dbg_wr) begin
                        dbg.dbg_rdata <= rf_data1;
                    end
                    dbg.dbg_ack <= 1'b1;
                    state       <= DBG_ACK;
                end
                DBG_ACK: begin
                    state <= IDLE;
                end
                CLEAR: begin
                    // Requests seen mid-clear are absorbed; the running sweep covers them.
                    clr_pend <= 1'b0;
                    clr_cnt  <= clr_cnt + 1'b1;
                    if (clr_cnt == CLR_LAST) begin
                        state    <= IDLE;
                        clr_done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        core_stall = 1'b0;
        rf_we      = core_we;
        rf_dst     = core_dst;
        rf_data    = core_data;
        rf_src1    = core_src1;
        case (state)
            DBG_ACC: begin
                core_stall = 1'b1;
                rf_we      = dbg.dbg_wr;
                rf_dst     = dbg.dbg_addr;
                rf_data    = dbg.dbg_wdata;
                rf_src1    = dbg.dbg_addr;
            end
            CLEAR: begin
                core_stall = 1'b1;
                rf_we      = 1'b1;
                rf_dst     = clr_cnt;
                rf_data    = CLR_VALUE;
            end
            default: begin
            end
        endcase
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: a behavioural register file behind the rf_* port and a
// shadow copy of its contents that supplies expected debug read data.
module tb_regfile_arbiter;
    import regfile_arb_pkg::*;

    localparam int          MAX_WAIT  = 4;
    localparam logic [7:0]  CLR_VALUE = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       core_we;
    logic [3:0] core_dst;
    logic [7:0] core_data;
    logic [3:0] core_src1;
    logic       core_stall;
    logic       clr_start;
    logic       clr_done;
    logic       rf_we;
    logic [3:0] rf_dst;
    logic [7:0] rf_data;
    logic [3:0] rf_src1;
    logic [7:0] rf_data1;
    arb_state_t fsm_state;

    regfile_arbiter_if dbg_if();

    regfile_arbiter #(
        .MAX_WAIT  (MAX_WAIT),
        .CLR_VALUE (CLR_VALUE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_we    (core_we),
        .core_dst   (core_dst),
        .core_data  (core_data),
        .core_src1  (core_src1),
        .core_stall (core_stall),
        .dbg        (dbg_if),
        .clr_start  (clr_start),
        .clr_done   (clr_done),
        .rf_we      (rf_we),
        .rf_dst     (rf_dst),
        .rf_data    (rf_data),
        .rf_src1    (rf_src1),
        .rf_data1   (rf_data1),
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    logic [7:0] rf_mem [16];
    always_ff @(posedge clk) begin
        if (rf_we) rf_mem[rf_dst] <= rf_data;
    end
    assign rf_data1 = rf_mem[rf_src1];

    logic [7:0] shadow [16];
    logic [7:0] exp_q [$];
    int errors = 0;
    int checks = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        core_we           = 1'b0;
        core_dst          = 4'd0;
        core_data         = 8'h00;
        core_src1         = 4'd0;
        clr_start         = 1'b0;
        dbg_if.dbg_req    = 1'b0;
        dbg_if.dbg_wr     = 1'b0;
        dbg_if.dbg_addr   = 4'd0;
        dbg_if.dbg_wdata  = 8'h00;
    endtask

    task automatic core_write(input logic [3:0] dst, input logic [7:0] data);
        @(posedge clk); #1;
        core_we   = 1'b1;
        core_dst  = dst;
        core_data = data;
        core_src1 = ~dst;
        @(negedge clk);
        checks++;
        if ({core_stall, rf_we, rf_dst, rf_data, rf_src1, dbg_if.dbg_ack, clr_done} !==
            {1'b0, 1'b1, dst, data, ~dst, 1'b0, 1'b0})
            $display("FAIL passthrough dst=%0d: got %h expected %h", dst,
                     {core_stall, rf_we, rf_dst, rf_data, rf_src1, dbg_if.dbg_ack, clr_done},
                     {1'b0, 1'b1, dst, data, ~dst, 1'b0, 1'b0});
        if ({core_stall, rf_we, rf_dst, rf_data, rf_src1, dbg_if.dbg_ack, clr_done} !==
            {1'b0, 1'b1, dst, data, ~dst, 1'b0, 1'b0}) errors++;
        shadow[dst] = data;
    endtask

    task automatic core_stop();
        @(posedge clk); #1;
        core_we = 1'b0;
    endtask

    // Raise a debug request and follow it to the ack; exp_lat counts cycles from the
    // request to the DBG_ACC cycle (1 when uncontended, 1 + MAX_WAIT when starved).
    task automatic dbg_xfer(input logic wr, input logic [3:0] addr, input logic [7:0] wdata,
                            input int exp_lat);
        int lat = 0;
        bit got = 1'b0;
        logic [7:0] exp_d;
        if (wr) shadow[addr] = wdata;
        else exp_q.push_back(shadow[addr]);
        @(posedge clk); #1;
        dbg_if.dbg_req   = 1'b1;
        dbg_if.dbg_wr    = wr;
        dbg_if.dbg_addr  = addr;
        dbg_if.dbg_wdata = wdata;
        while (!got && lat < 40) begin
            @(negedge clk);
            if (core_stall === 1'b1) got = 1'b1;
            else lat++;
        end
        checks++;
        if (!got || lat != exp_lat) begin
            errors++;
            $display("FAIL dbg_grant_latency addr=%0d: got %0d (granted=%0d) expected %0d",
                     addr, lat, got, exp_lat);
        end
        if (got) begin
            checks++;
            if ({rf_we, rf_dst, rf_src1, fsm_state} !== {wr, addr, addr, DBG_ACC}) begin
                errors++;
                $display("FAIL dbg_acc_port addr=%0d: got %h expected %h", addr,
                         {rf_we, rf_dst, rf_src1, fsm_state}, {wr, addr, addr, DBG_ACC});
            end
            if (wr) begin
                checks++;
                if (rf_data !== wdata) begin
                    errors++;
                    $display("FAIL dbg_acc_wdata: got %h expected %h", rf_data, wdata);
                end
            end
            @(negedge clk);
            checks++;
            if ({dbg_if.dbg_ack, core_stall} !== 2'b10) begin
                errors++;
                $display("FAIL dbg_ack addr=%0d: got ack=%b stall=%b expected ack=1 stall=0",
                         addr, dbg_if.dbg_ack, core_stall);
            end
            if (!wr && exp_q.size() > 0) begin
                exp_d = exp_q.pop_front();
                checks++;
                if (dbg_if.dbg_rdata !== exp_d) begin
                    errors++;
                    $display("FAIL dbg_rdata addr=%0d: got %h expected %h",
                             addr, dbg_if.dbg_rdata, exp_d);
                end
            end
        end else if (!wr && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end
        @(posedge clk); #1;
        dbg_if.dbg_req = 1'b0;
        @(negedge clk);
        checks++;
        if (dbg_if.dbg_ack !== 1'b0) begin
            errors++;
            $display("FAIL dbg_ack_pulse addr=%0d: got %b expected 0", addr, dbg_if.dbg_ack);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({core_stall, dbg_if.dbg_ack, dbg_if.dbg_rdata, clr_done, fsm_state} !==
            {1'b0, 1'b0, 8'h00, 1'b0, IDLE}) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h",
                     {core_stall, dbg_if.dbg_ack, dbg_if.dbg_rdata, clr_done, fsm_state},
                     {1'b0, 1'b0, 8'h00, 1'b0, IDLE});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_passthrough();
        logic [3:0] dsts [7] = '{4'd3, 4'd6, 4'd9, 4'd10, 4'd12, 4'd4, 4'd5};
        logic [7:0] vals [7] = '{8'h5A, 8'd214, 8'h10, 8'h77, 8'hC4, 8'h0F, 8'h55};
        for (int i = 0; i < 7; i++) core_write(dsts[i], vals[i]);
        core_stop();
    endtask

    task automatic test_dbg_read();
        dbg_xfer(1'b0, 4'd6, 8'h00, 1);
        dbg_xfer(1'b0, 4'd3, 8'h00, 1);
        checks++;
        if (dbg_if.dbg_rdata !== 8'h5A) begin
            errors++;
            $display("FAIL dbg_rdata_hold: got %h expected 5a", dbg_if.dbg_rdata);
        end
    endtask

    task automatic test_starvation();
        @(posedge clk); #1;
        core_we   = 1'b1;
        core_dst  = 4'd4;
        core_data = 8'h11;
        shadow[4] = 8'h11;
        dbg_xfer(1'b1, 4'd2, 8'hA5, 1 + MAX_WAIT);
        // Back-to-back starved read of the register the core is writing in the grant cycle.
        core_dst  = 4'd9;
        core_data = 8'h42;
        shadow[9] = 8'h42;
        dbg_xfer(1'b0, 4'd9, 8'h00, 1 + MAX_WAIT);
        core_stop();
        dbg_xfer(1'b0, 4'd2, 8'h00, 1);
        dbg_xfer(1'b0, 4'd4, 8'h00, 1);
    endtask

    task automatic test_clear();
        @(posedge clk); #1;
        clr_start = 1'b1;
        core_src1 = 4'd11;
        @(negedge clk);
        checks++;
        if ({core_stall, clr_done, fsm_state} !== {1'b0, 1'b0, IDLE}) begin
            errors++;
            $display("FAIL clear_entry: got %h expected %h",
                     {core_stall, clr_done, fsm_state}, {1'b0, 1'b0, IDLE});
        end
        @(posedge clk); #1;
        clr_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if ({core_stall, rf_we, rf_dst, rf_data, rf_src1, clr_done} !==
                {1'b1, 1'b1, i[3:0], CLR_VALUE, 4'd11, 1'b0}) begin
                errors++;
                $display("FAIL clear_write %0d: got %h expected %h", i,
                         {core_stall, rf_we, rf_dst, rf_data, rf_src1, clr_done},
                         {1'b1, 1'b1, i[3:0], CLR_VALUE, 4'd11, 1'b0});
            end
            if (i == 7) begin
                @(posedge clk); #1;
                clr_start = 1'b1;
            end else if (i == 8) begin
                @(posedge clk); #1;
                clr_start = 1'b0;
            end
        end
        for (int r = 0; r < 16; r++) shadow[r] = CLR_VALUE;
        @(negedge clk);
        checks++;
        if ({core_stall, clr_done, rf_we} !== 3'b010) begin
            errors++;
            $display("FAIL clear_done: got %b expected 010", {core_stall, clr_done, rf_we});
        end
        @(negedge clk);
        checks++;
        if ({core_stall, clr_done, fsm_state} !== {1'b0, 1'b0, IDLE}) begin
            errors++;
            $display("FAIL clear_absorb: got %h expected %h",
                     {core_stall, clr_done, fsm_state}, {1'b0, 1'b0, IDLE});
        end
        dbg_xfer(1'b0, 4'd13, 8'h00, 1);
    endtask

    task automatic test_clear_then_dbg();
        core_write(4'd3, 8'h3C);
        core_stop();
        @(posedge clk); #1;
        clr_start        = 1'b1;
        dbg_if.dbg_req   = 1'b1;
        dbg_if.dbg_wr    = 1'b0;
        dbg_if.dbg_addr  = 4'd3;
        for (int r = 0; r < 16; r++) shadow[r] = CLR_VALUE;
        exp_q.push_back(shadow[3]);
        @(negedge clk);
        checks++;
        if (core_stall !== 1'b0) begin
            errors++;
            $display("FAIL clr_dbg_entry: got stall=%b expected 0", core_stall);
        end
        @(posedge clk); #1;
        clr_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if ({core_stall, rf_we, rf_dst} !== {1'b1, 1'b1, i[3:0]}) begin
                errors++;
                $display("FAIL clr_dbg_clear %0d: got %h expected %h", i,
                         {core_stall, rf_we, rf_dst}, {1'b1, 1'b1, i[3:0]});
            end
        end
        @(negedge clk);
        checks++;
        if ({clr_done, core_stall, dbg_if.dbg_ack} !== 3'b100) begin
            errors++;
            $display("FAIL clr_dbg_done: got %b expected 100",
                     {clr_done, core_stall, dbg_if.dbg_ack});
        end
        @(negedge clk);
        checks++;
        if ({core_stall, rf_we, rf_src1, fsm_state} !== {1'b1, 1'b0, 4'd3, DBG_ACC}) begin
            errors++;
            $display("FAIL clr_dbg_acc: got %h expected %h",
                     {core_stall, rf_we, rf_src1, fsm_state}, {1'b1, 1'b0, 4'd3, DBG_ACC});
        end
        @(negedge clk);
        checks++;
        if (dbg_if.dbg_ack !== 1'b1) begin
            errors++;
            $display("FAIL clr_dbg_ack: got %b expected 1", dbg_if.dbg_ack);
        end
        if (exp_q.size() > 0) begin
            logic [7:0] exp_d;
            exp_d = exp_q.pop_front();
            checks++;
            if (dbg_if.dbg_rdata !== exp_d) begin
                errors++;
                $display("FAIL clr_dbg_rdata: got %h expected %h", dbg_if.dbg_rdata, exp_d);
            end
        end
        @(posedge clk); #1;
        dbg_if.dbg_req = 1'b0;
    endtask

    task automatic test_reset_mid_clear();
        core_write(4'd2, 8'h2B);
        core_write(4'd5, 8'h55);
        core_write(4'd12, 8'hC4);
        core_stop();
        dbg_xfer(1'b0, 4'd12, 8'h00, 1);
        @(posedge clk); #1;
        clr_start = 1'b1;
        @(posedge clk); #1;
        clr_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({core_stall, rf_dst} !== {1'b1, i[3:0]}) begin
                errors++;
                $display("FAIL abort_clear_write %0d: got %h expected %h", i,
                         {core_stall, rf_dst}, {1'b1, i[3:0]});
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({core_stall, rf_we, dbg_if.dbg_ack, dbg_if.dbg_rdata, clr_done, fsm_state} !==
            {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, IDLE}) begin
            errors++;
            $display("FAIL abort_async_reset: got %h expected %h",
                     {core_stall, rf_we, dbg_if.dbg_ack, dbg_if.dbg_rdata, clr_done, fsm_state},
                     {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, IDLE});
        end
        for (int r = 0; r < 5; r++) shadow[r] = CLR_VALUE;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({clr_done, core_stall} !== 2'b00) begin
                errors++;
                $display("FAIL abort_no_done %0d: got %b expected 00", i, {clr_done, core_stall});
            end
        end
        dbg_xfer(1'b0, 4'd10, 8'h00, 1);
        dbg_xfer(1'b0, 4'd2, 8'h00, 1);
        dbg_xfer(1'b0, 4'd5, 8'h00, 1);
        dbg_xfer(1'b0, 4'd12, 8'h00, 1);
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_dbg_read();
        test_starvation();
        test_clear();
        test_clear_then_dbg();
        test_reset_mid_clear();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
